// File: rtl/ae_set_pkg.sv
// -----------------------------------------------------------------------------
// ae_set_pkg
// Shared definitions for the ae_set exposure-control path.
//   state_e    : step-controller FSM encoding (IDLE / HOLD / REPEAT)
//   t1ms_of()  : terminal count of the 1 ms prescaler for a given clock in Hz
//   ms_cnt_w() : width of a ms counter able to reach max(hold, rep)
//   MS_CNT_W   : that width for the default 500 ms hold / 100 ms repeat
// -----------------------------------------------------------------------------
package ae_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    function automatic int unsigned t1ms_of(input logic [63:0] ref_clk);
        return 32'(ref_clk / 64'd1000 - 64'd1);
    endfunction

    function automatic int ms_cnt_w(input int hold_ms, input int rep_ms);
        return $clog2(((hold_ms > rep_ms) ? hold_ms : rep_ms) + 1);
    endfunction

    localparam int MS_CNT_W = ms_cnt_w(500, 100);

endpackage

// File: rtl/ae_key_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// ae_key_step_ctrl_if
// Key-pulse inputs and exposure handshake of ae_key_step_ctrl.
//   I_inc_down / I_inc_up : INC key press / release pulses (debounced)
//   I_dec_down / I_dec_up : DEC key press / release pulses (debounced)
//   I_exp_ack             : writer has sampled O_exp_val
//   O_exp_val             : current exposure value
//   O_exp_req             : update pending, held until acknowledged
//   O_repeat              : high while in auto-repeat
// master = key blocks + register writer side, slave = step controller.
// -----------------------------------------------------------------------------
interface ae_key_step_ctrl_if #(
    parameter int EXP_W = 16
);
    logic             I_inc_down;
    logic             I_inc_up;
    logic             I_dec_down;
    logic             I_dec_up;
    logic             I_exp_ack;
    logic [EXP_W-1:0] O_exp_val;
    logic             O_exp_req;
    logic             O_repeat;

    modport master (
        output I_inc_down, I_inc_up, I_dec_down, I_dec_up, I_exp_ack,
        input  O_exp_val, O_exp_req, O_repeat
    );

    modport slave (
        input  I_inc_down, I_inc_up, I_dec_down, I_dec_up, I_exp_ack,
        output O_exp_val, O_exp_req, O_repeat
    );
endinterface

// File: rtl/ae_ms_tick.sv
// -----------------------------------------------------------------------------
// ae_ms_tick
// Free-running prescaler: counts 0..T1MS and pulses tick_1ms for one cycle
// on the terminal count, then wraps.
//   I_sysclk : system clock
//   I_rstn   : asynchronous active-low reset
//   tick_1ms : one-cycle pulse every T1MS+1 clocks
// -----------------------------------------------------------------------------
module ae_ms_tick #(
    parameter int unsigned T1MS = 49_999
) (
    input  logic I_sysclk,
    input  logic I_rstn,
    output logic tick_1ms
);
    localparam int CNT_W = (T1MS > 0) ? $clog2(T1MS + 1) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_1ms = (cnt_q == CNT_W'(T1MS));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge I_sysclk or negedge I_rstn) begin
        if (!I_rstn) begin
            cnt_q <= '0;
        end else if (tick_1ms) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/ae_key_step_ctrl.sv
// -----------------------------------------------------------------------------
// ae_key_step_ctrl
// Turns INC/DEC key press/release pulses into a saturating exposure value.
// A press steps once immediately; holding for HOLD_MS enters auto-repeat,
// stepping every REP_MS until the held key is released. Every value change
// raises O_exp_req toward the sensor register writer until I_exp_ack.
//   I_sysclk : system clock
//   I_rstn   : asynchronous active-low reset
//   bus      : key pulses, exposure value and req/ack (slave modport)
// -----------------------------------------------------------------------------
module ae_key_step_ctrl
    import ae_set_pkg::*;
#(
    parameter logic [63:0]      REF_CLK  = 64'd50_000_000,
    parameter int               EXP_W    = 16,
    parameter logic [EXP_W-1:0] EXP_MIN  = 16'd4,
    parameter logic [EXP_W-1:0] EXP_MAX  = 16'd1000,
    parameter logic [EXP_W-1:0] EXP_INIT = 16'd200,
    parameter logic [EXP_W-1:0] EXP_STEP = 16'd10,
    parameter int               HOLD_MS  = 500,
    parameter int               REP_MS   = 100
) (
    input  logic               I_sysclk,
    input  logic               I_rstn,
    ae_key_step_ctrl_if.slave  bus
);
    localparam int unsigned T1MS = t1ms_of(REF_CLK);
    localparam int          MS_W = ms_cnt_w(HOLD_MS, REP_MS);

    // Bounds widened by one bit so the step arithmetic can never wrap.
    localparam logic [EXP_W:0] MAX_X     = {1'b0, EXP_MAX};
    localparam logic [EXP_W:0] DEC_FLOOR = {1'b0, EXP_MIN} + {1'b0, EXP_STEP};

    logic            tick_1ms;
    state_e          state_q, state_d;
    logic            dir_q, dir_d;      // 0 = inc, 1 = dec
    logic [MS_W-1:0] ms_cnt_q;
    logic [EXP_W-1:0] val_q, val_next;
    logic [EXP_W:0]  inc_sum;
    logic            req_q;
    logic            step_req, ms_clr, held_up, val_chg;

    ae_ms_tick #(.T1MS(T1MS)) u_ms_tick (
        .I_sysclk (I_sysclk),
        .I_rstn   (I_rstn),
        .tick_1ms (tick_1ms)
    );

    // Only the release of the key that started the press ends it.
    assign held_up = dir_q ? bus.I_dec_up : bus.I_inc_up;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        dir_d    = dir_q;
        step_req = 1'b0;
        ms_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Simultaneous presses are ambiguous and dropped.
                if (bus.I_inc_down ^ bus.I_dec_down) begin
                    dir_d    = bus.I_dec_down;
                    step_req = 1'b1;
                    ms_clr   = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (held_up) begin
                    state_d = ST_IDLE;
                end else if (ms_cnt_q == MS_W'(HOLD_MS)) begin
                    step_req = 1'b1;
                    ms_clr   = 1'b1;
                    state_d  = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (held_up) begin
                    state_d = ST_IDLE;
                end else if (ms_cnt_q == MS_W'(REP_MS)) begin
                    step_req = 1'b1;
                    ms_clr   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // dir_d already carries the new direction when the step comes from IDLE.
    always_comb begin
        inc_sum = {1'b0, val_q} + {1'b0, EXP_STEP};
        if (!dir_d) begin
            val_next = (inc_sum > MAX_X) ? EXP_MAX : inc_sum[EXP_W-1:0];
        end else begin
            val_next = ({1'b0, val_q} < DEC_FLOOR) ? EXP_MIN : val_q - EXP_STEP;
        end
    end

    // A saturated step is not a change and must not raise a request.
    assign val_chg = step_req && (val_next != val_q);

    always_ff @(posedge I_sysclk or negedge I_rstn) begin
        if (!I_rstn) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            ms_cnt_q <= '0;
            val_q    <= EXP_INIT;
            req_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;

            if (ms_clr) begin
                ms_cnt_q <= '0;
            end else if (tick_1ms && (state_q != ST_IDLE)) begin
                ms_cnt_q <= ms_cnt_q + 1'b1;
            end

            if (val_chg) begin
                val_q <= val_next;
            end

            // A new value outranks an ack landing in the same cycle, so the
            // writer always gets asked for the latest value.
            if (val_chg) begin
                req_q <= 1'b1;
            end else if (bus.I_exp_ack) begin
                req_q <= 1'b0;
            end
        end
    end

    assign bus.O_exp_val = val_q;
    assign bus.O_exp_req = req_q;
    assign bus.O_repeat  = (state_q == ST_REPEAT);
endmodule

// File: tb/tb_ae_key_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ae_key_step_ctrl
// Directed bench for ae_key_step_ctrl at REF_CLK = 10_000 (1 ms = 10 cycles).
// Three instances: default EXP_INIT = 200, plus 995 and 9 for saturation.
// -----------------------------------------------------------------------------
module tb_ae_key_step_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ae_key_step_ctrl_if #(.EXP_W(16)) bus ();
    ae_key_step_ctrl_if #(.EXP_W(16)) bus_hi ();
    ae_key_step_ctrl_if #(.EXP_W(16)) bus_lo ();

    ae_key_step_ctrl #(.REF_CLK(64'd10_000)) u_dut (
        .I_sysclk (clk),
        .I_rstn   (rst_n),
        .bus      (bus)
    );

    ae_key_step_ctrl #(.REF_CLK(64'd10_000), .EXP_INIT(16'd995)) u_dut_hi (
        .I_sysclk (clk),
        .I_rstn   (rst_n),
        .bus      (bus_hi)
    );

    ae_key_step_ctrl #(.REF_CLK(64'd10_000), .EXP_INIT(16'd9)) u_dut_lo (
        .I_sysclk (clk),
        .I_rstn   (rst_n),
        .bus      (bus_lo)
    );

    typedef struct packed {
        logic        inc_down;
        logic        inc_up;
        logic        dec_down;
        logic        dec_up;
        logic        ack;
        logic [15:0] val;
        logic        req;
        logic        rep;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Waits at negedges for the main value to leave `from`, at most `bound` cycles.
    task automatic wait_change(input logic [15:0] from, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.O_exp_val != from) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_main(input string tag, input logic [15:0] val,
                              input logic req, input logic rep);
        check({tag, ".val"}, 32'(bus.O_exp_val), 32'(val));
        check({tag, ".req"}, 32'(bus.O_exp_req), 32'(req));
        check({tag, ".rep"}, 32'(bus.O_repeat),  32'(rep));
    endtask

    initial begin
        int unsigned t0;
        int unsigned t_step;
        bit          ok;

        // inc_dn inc_up dec_dn dec_up ack | val req rep
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd200, 1'b0, 1'b0}; // idle after reset
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd210, 1'b1, 1'b0}; // inc press steps
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd210, 1'b1, 1'b0}; // req held
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd210, 1'b0, 1'b0}; // ack clears req
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd210, 1'b0, 1'b0}; // release
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd210, 1'b0, 1'b0}; // ack with req low
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd210, 1'b0, 1'b0}; // both pressed: ignored
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd210, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd200, 1'b1, 1'b0}; // dec press steps
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd200, 1'b1, 1'b0}; // other key up ignored
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd200, 1'b1, 1'b0}; // other key down ignored
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd200, 1'b0, 1'b0}; // release + ack
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd200, 1'b0, 1'b0}; // stray up in idle
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd200, 1'b0, 1'b0};

        {bus.I_inc_down, bus.I_inc_up, bus.I_dec_down, bus.I_dec_up, bus.I_exp_ack} = '0;
        {bus_hi.I_inc_down, bus_hi.I_inc_up, bus_hi.I_dec_down, bus_hi.I_dec_up, bus_hi.I_exp_ack} = '0;
        {bus_lo.I_inc_down, bus_lo.I_inc_up, bus_lo.I_dec_down, bus_lo.I_dec_up, bus_lo.I_exp_ack} = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_main("reset", 16'd200, 1'b0, 1'b0);
        check("reset.hi_val", 32'(bus_hi.O_exp_val), 32'd995);
        rst_n = 1'b1;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < NV; i++) begin
            bus.I_inc_down = vecs[i].inc_down;
            bus.I_inc_up   = vecs[i].inc_up;
            bus.I_dec_down = vecs[i].dec_down;
            bus.I_dec_up   = vecs[i].dec_up;
            bus.I_exp_ack  = vecs[i].ack;
            @(negedge clk);
            check_main($sformatf("vec%0d", i), vecs[i].val, vecs[i].req, vecs[i].rep);
        end
        {bus.I_inc_down, bus.I_inc_up, bus.I_dec_down, bus.I_dec_up, bus.I_exp_ack} = '0;

        // Saturation: 995 -> 1000 then stuck; 9 -> 4 then stuck
        bus_hi.I_inc_down = 1'b1;
        bus_lo.I_dec_down = 1'b1;
        @(negedge clk);
        bus_hi.I_inc_down = 1'b0;
        bus_lo.I_dec_down = 1'b0;
        check("sat_hi.val1", 32'(bus_hi.O_exp_val), 32'd1000);
        check("sat_hi.req1", 32'(bus_hi.O_exp_req), 32'd1);
        check("sat_lo.val1", 32'(bus_lo.O_exp_val), 32'd4);
        check("sat_lo.req1", 32'(bus_lo.O_exp_req), 32'd1);
        bus_hi.I_inc_up = 1'b1; bus_hi.I_exp_ack = 1'b1;
        bus_lo.I_dec_up = 1'b1; bus_lo.I_exp_ack = 1'b1;
        @(negedge clk);
        bus_hi.I_inc_up = 1'b0; bus_hi.I_exp_ack = 1'b0;
        bus_lo.I_dec_up = 1'b0; bus_lo.I_exp_ack = 1'b0;
        check("sat_hi.ack", 32'(bus_hi.O_exp_req), 32'd0);
        check("sat_lo.ack", 32'(bus_lo.O_exp_req), 32'd0);
        bus_hi.I_inc_down = 1'b1;
        bus_lo.I_dec_down = 1'b1;
        @(negedge clk);
        bus_hi.I_inc_down = 1'b0;
        bus_lo.I_dec_down = 1'b0;
        check("sat_hi.val2", 32'(bus_hi.O_exp_val), 32'd1000);
        check("sat_hi.req2", 32'(bus_hi.O_exp_req), 32'd0);
        check("sat_lo.val2", 32'(bus_lo.O_exp_val), 32'd4);
        check("sat_lo.req2", 32'(bus_lo.O_exp_req), 32'd0);
        bus_hi.I_inc_up = 1'b1;
        bus_lo.I_dec_up = 1'b1;
        @(negedge clk);
        bus_hi.I_inc_up = 1'b0;
        bus_lo.I_dec_up = 1'b0;

        // Long INC hold for 950 ms: steps at 0, ~500, ~600, ~700, ~800, ~900 ms
        bus.I_inc_down = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.I_inc_down = 1'b0;
        check_main("lh_press", 16'd210, 1'b1, 1'b0);
        wait_until(t0 + 4900);
        check_main("lh_490ms", 16'd210, 1'b1, 1'b0);
        wait_change(16'd210, 300, ok);
        check("lh_enter_repeat_seen", 32'(ok), 32'd1);
        check_main("lh_first_repeat", 16'd220, 1'b1, 1'b1);
        t_step = cyc;

        // Ack held across the next repeat step: the step cycle must keep req high.
        wait_until(t_step + 980);
        bus.I_exp_ack = 1'b1;
        wait_change(16'd220, 60, ok);
        check("lh_second_repeat_seen", 32'(ok), 32'd1);
        check_main("ack_with_step", 16'd230, 1'b1, 1'b1);
        @(negedge clk);
        bus.I_exp_ack = 1'b0;
        check("ack_after_step.req", 32'(bus.O_exp_req), 32'd0);

        // DEC pulses during the INC repeat are ignored.
        wait_until(t0 + 6500);
        bus.I_dec_down = 1'b1;
        @(negedge clk);
        bus.I_dec_down = 1'b0;
        wait_until(t0 + 6600);
        bus.I_dec_up = 1'b1;
        @(negedge clk);
        bus.I_dec_up = 1'b0;
        wait_until(t0 + 6900);
        check("other_key.val", 32'(bus.O_exp_val), 32'd230);
        check("other_key.rep", 32'(bus.O_repeat), 32'd1);
        wait_until(t0 + 7500);
        check("lh_750ms.val", 32'(bus.O_exp_val), 32'd240);
        wait_until(t0 + 8500);
        check("lh_850ms.val", 32'(bus.O_exp_val), 32'd250);
        wait_until(t0 + 9300);
        check_main("lh_930ms", 16'd260, 1'b1, 1'b1);
        wait_until(t0 + 9500);
        bus.I_inc_up = 1'b1;
        @(negedge clk);
        bus.I_inc_up = 1'b0;
        check("lh_release.rep", 32'(bus.O_repeat), 32'd0);
        check("lh_release.val", 32'(bus.O_exp_val), 32'd260);
        repeat (1500) @(negedge clk);
        check("lh_idle.val", 32'(bus.O_exp_val), 32'd260);

        // Reset asserted mid-REPEAT (DEC hold: 260 -> 250 -> 240)
        bus.I_dec_down = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.I_dec_down = 1'b0;
        check("rst_dec_press.val", 32'(bus.O_exp_val), 32'd250);
        wait_until(t0 + 5200);
        check_main("pre_reset", 16'd240, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_main("async_reset", 16'd200, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Short INC press after reset: up 50 ms later, ack, then nothing more.
        bus.I_inc_down = 1'b1;
        @(negedge clk);
        bus.I_inc_down = 1'b0;
        check_main("post_reset_press", 16'd210, 1'b1, 1'b0);
        repeat (500) @(negedge clk);
        bus.I_inc_up = 1'b1;
        bus.I_exp_ack = 1'b1;
        @(negedge clk);
        bus.I_inc_up = 1'b0;
        bus.I_exp_ack = 1'b0;
        check("short_ack.req", 32'(bus.O_exp_req), 32'd0);
        repeat (6000) @(negedge clk);
        check_main("short_idle", 16'd210, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ae_key_step_ctrl.md
Name: ae_key_step_ctrl

Overview:
- Sits directly downstream of the two debounced key blocks (INC key, DEC key) in the ae_set path.
- Consumes their single-cycle press/release pulses and turns them into a saturating exposure value.
- A press gives one immediate step. A long press enters auto-repeat.
- Every value change raises a req/ack handshake toward the sensor register writer (SCCB/I2C issue stage).

Parameters:
- REF_CLK, 64'd50_000_000, system clock frequency in Hz; sets the 1 ms tick (T1MS = REF_CLK/1000 - 1).
- EXP_W, 16, exposure value width.
- EXP_MIN, 16'd4, lower saturation bound.
- EXP_MAX, 16'd1000, upper saturation bound.
- EXP_INIT, 16'd200, reset value (EXP_MIN <= EXP_INIT <= EXP_MAX).
- EXP_STEP, 16'd10, increment/decrement per step.
- HOLD_MS, 500, hold time in ms before auto-repeat starts.
- REP_MS, 100, auto-repeat period in ms.

Ports:
- I_sysclk  in  1  system clock, the only clock.
- I_rstn  in  1  asynchronous active-low reset.
- I_inc_down  in  1  one-cycle pulse: INC key pressed (debounced).
- I_inc_up  in  1  one-cycle pulse: INC key released.
- I_dec_down  in  1  one-cycle pulse: DEC key pressed.
- I_dec_up  in  1  one-cycle pulse: DEC key released.
- I_exp_ack  in  1  writer has sampled O_exp_val.
- O_exp_val  out  EXP_W  current exposure value.
- O_exp_req  out  1  update pending; level signal, held until acknowledged.
- O_repeat  out  1  high while in auto-repeat.

Behaviour:
- Clocking and reset:
  - One clock (I_sysclk). Reset is asynchronous and active-low on I_rstn.
  - Reset values: O_exp_val = EXP_INIT, O_exp_req = 0, O_repeat = 0, FSM = IDLE, ms prescaler = 0, ms counter = 0.
- ms tick:
  - Free-running prescaler counts 0..T1MS.
  - tick_1ms is high for one cycle when the count equals T1MS, then the count wraps to 0.
- FSM states: IDLE, HOLD, REPEAT. A dir register (0 = inc, 1 = dec) is captured on leaving IDLE.
  - IDLE:
    - I_inc_down alone: dir = 0, step request, go to HOLD, clear ms counter.
    - I_dec_down alone: dir = 1, same actions.
    - Both down pulses in the same cycle: ignored, stay IDLE.
    - Up pulses: ignored.
  - HOLD:
    - ms counter increments on each tick_1ms.
    - Up pulse of the held key: go to IDLE.
    - When the counter reaches HOLD_MS: step request, clear the counter, go to REPEAT.
  - REPEAT:
    - O_repeat = 1.
    - When the ms counter reaches REP_MS: step request, clear the counter.
    - Up pulse of the held key: go to IDLE, O_repeat = 0 on the next cycle.
  - In HOLD and REPEAT, the other key's down/up pulses are ignored.
  - An up pulse in the same cycle as a timer expiry takes priority: no step, go to IDLE.
- Timing tolerance:
  - The counter starts at an arbitrary prescaler phase, so hold and repeat periods are accurate to -1 ms / +0.
- Step arithmetic (computed in EXP_W+1 bits, no wrap):
  - inc: new = (val + EXP_STEP > EXP_MAX) ? EXP_MAX : val + EXP_STEP.
  - dec: new = (val < EXP_MIN + EXP_STEP) ? EXP_MIN : val - EXP_STEP.
  - O_exp_val updates on the clock edge after the step request. A down pulse at cycle N gives a new value at N+1.
- Handshake:
  - When a step changes the value, O_exp_req is set high in the same cycle O_exp_val updates.
  - A saturated step (new == val) leaves O_exp_req unchanged.
  - I_exp_ack while req = 1 clears req on the next edge, unless a value change occurs in that same cycle, in which case req stays 1.
  - Ack while req = 0 is ignored.
  - The writer samples O_exp_val in the ack cycle. O_exp_val may change while req is high; only the latest value is guaranteed to be delivered.
- Reset mid-operation: all state returns to reset values immediately, with no pending req preserved.

Decomposition:
- Shared package ae_set_pkg holds:
  - state encodings ST_IDLE/ST_HOLD/ST_REPEAT (2 bits);
  - function for T1MS from REF_CLK;
  - the ms counter width constant (clog2 of max(HOLD_MS, REP_MS) + 1).
- One sub-module: ae_ms_tick (prescaler producing tick_1ms), reusable by other ae_set timers.
- FSM, saturating arithmetic and handshake stay in ae_key_step_ctrl.

Test Plan:
(All runs use REF_CLK = 10_000, so T1MS = 9 and 1 ms = 10 cycles; other parameters at default.)
- Short inc press: down pulse, up pulse 50 ms later -> O_exp_val goes 200 -> 210 one cycle after the down pulse; req = 1; ack -> req = 0 next cycle; no further change.
- Long inc hold, 950 ms -> steps at 0, ~500, ~600, ~700, ~800, ~900 ms; final value 260; O_repeat high from ~500 ms until one cycle after the up pulse.
- Saturation with EXP_INIT = 995: inc press -> 1000, req = 1; ack, then a second inc press -> value stays 1000 and req stays 0. The mirror case with dec from 9 -> 4, then stuck at 4.
- Simultaneous I_inc_down and I_dec_down -> no value change, FSM stays IDLE. Separately: ack in the same cycle as a repeat step -> req remains 1 and the value advances.
- Other-key pulses during an INC hold -> ignored; value tracks INC repeats only.
- Async reset asserted mid-REPEAT with value 240 and req = 1 -> O_exp_val = 200, req = 0, O_repeat = 0 immediately; a new press after release behaves as from reset.
